// File: rtl/l2_pool_if.sv
// Window-input and pooled-output bus of the layer-2 max-pool stage.
// Handshake: a position moves on every rising edge with out_vld=1 and out_rdy=1.
// While out_vld=1 and out_rdy=0, out_vld, out_idx and dout_* hold steady.
interface l2_pool_if #(
   parameter int DW = 18,
   parameter int IW = 5
);
   logic                rd;
   logic [3:0][DW-1:0]  din_0;
   logic [3:0][DW-1:0]  din_1;
   logic [3:0][DW-1:0]  din_2;
   logic [3:0][DW-1:0]  din_3;
   logic                full;
   logic                out_vld;
   logic                out_rdy;
   logic [IW-1:0]       out_idx;
   logic [DW-1:0]       dout_0;
   logic [DW-1:0]       dout_1;
   logic [DW-1:0]       dout_2;
   logic [DW-1:0]       dout_3;
   logic                done;

   modport master (
      input  rd, din_0, din_1, din_2, din_3, out_rdy,
      output full, out_vld, out_idx, dout_0, dout_1, dout_2, dout_3, done
   );

   modport slave (
      output rd, din_0, din_1, din_2, din_3, out_rdy,
      input  full, out_vld, out_idx, dout_0, dout_1, dout_2, dout_3, done
   );
endinterface

// File: rtl/l2_pool.sv
// 2x2 max-pool after layer 2: snoops RAM reads, stores one max per window and channel,
// then streams the NWIN pooled positions out over a valid/ready handshake.
module l2_pool #(
   parameter int DW   = 18,
   parameter int NWIN = 25,
   parameter int IW   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_done,
   output logic        dbg_state,
   l2_pool_if.master   bus
);

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   localparam logic [IW-1:0] LAST = IW'(NWIN - 1);

   state_t              state;
   logic                rd_d;
   logic [IW-1:0]       wr_ptr;
   logic [IW-1:0]       rd_ptr;
   logic [IW-1:0]       rd_nxt;
   logic                full_q;
   logic                vld_q;
   logic                done_q;
   logic [DW-1:0]       dout_q  [4];
   logic [DW-1:0]       buf_mem [4][NWIN];
   logic [3:0][DW-1:0]  din_w   [4];
   logic [DW-1:0]       win_max [4];
   logic                wr_en;

   function automatic logic [DW-1:0] max4(input logic [3:0][DW-1:0] w);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      a = (w[0] > w[1]) ? w[0] : w[1];
      b = (w[2] > w[3]) ? w[2] : w[3];
      return (a > b) ? a : b;
   endfunction

   assign din_w[0] = bus.din_0;
   assign din_w[1] = bus.din_1;
   assign din_w[2] = bus.din_2;
   assign din_w[3] = bus.din_3;

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         win_max[c] = max4(din_w[c]);
      end
   end

   // Window data is valid in the cycle after the snooped read strobe.
   assign wr_en  = (state == FILL) && rd_d && !tx_done;
   assign rd_nxt = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < 4; c++) begin
            buf_mem[c][wr_ptr] <= win_max[c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FILL;
         rd_d   <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         full_q <= 1'b0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
         for (int c = 0; c < 4; c++) dout_q[c] <= '0;
      end else if (tx_done) begin
         state  <= FILL;
         rd_d   <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         full_q <= 1'b0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
         for (int c = 0; c < 4; c++) dout_q[c] <= '0;
      end else begin
         case (state)
            FILL: begin
               done_q <= 1'b0;
               rd_d   <= bus.rd;
               if (rd_d) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (wr_ptr == LAST) begin
                     state  <= DRAIN;
                     full_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Reads arriving while draining are dropped.
               rd_d   <= 1'b0;
               done_q <= 1'b0;
               if (!vld_q) begin
                  vld_q <= 1'b1;
                  for (int c = 0; c < 4; c++) dout_q[c] <= buf_mem[c][rd_ptr];
               end else if (bus.out_rdy) begin
                  if (rd_ptr == LAST) begin
                     vld_q  <= 1'b0;
                     full_q <= 1'b0;
                     done_q <= 1'b1;
                     wr_ptr <= '0;
                     rd_ptr <= '0;
                     state  <= FILL;
                  end else begin
                     rd_ptr <= rd_nxt;
                     for (int c = 0; c < 4; c++) dout_q[c] <= buf_mem[c][rd_nxt];
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign bus.full    = full_q;
   assign bus.out_vld = vld_q;
   assign bus.out_idx = rd_ptr;
   assign bus.done    = done_q;
   assign bus.dout_0  = dout_q[0];
   assign bus.dout_1  = dout_q[1];
   assign bus.dout_2  = dout_q[2];
   assign bus.dout_3  = dout_q[3];
   assign dbg_state   = state;

endmodule

// File: tb/tb_l2_pool.sv
// Directed bench for l2_pool: frames of known windows, pooled results checked
// through an expected queue popped by an output monitor.
module tb_l2_pool;
   localparam int DW   = 18;
   localparam int NWIN = 25;
   localparam int IW   = 5;
   localparam int EW   = IW + 4 * DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx_done = 1'b0;
   logic dbg_state;

   l2_pool_if #(.DW(DW), .IW(IW)) bus ();

   l2_pool #(.DW(DW), .NWIN(NWIN), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_done   (tx_done),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   logic [EW-1:0] exp_q[$];
   logic          exp_done = 1'b0;
   logic          hold_vld = 1'b0;
   logic [EW-1:0] hold_val;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0][DW-1:0] win(input int c, input int k);
      logic [DW-1:0] v;
      v = DW'(k + 20 * c);
      if (c == 0) return {DW'(v + 1), DW'(2 * v), DW'(3 * v), v};
      else        return {v, DW'(3 * v), DW'(2 * v), DW'(v + 1)};
   endfunction

   function automatic logic [EW-1:0] exp_entry(input int p, input int base, input bit special);
      logic [DW-1:0] d [4];
      for (int c = 0; c < 4; c++) begin
         d[c] = special ? 18'h3FFFF : DW'(3 * (base + p + 20 * c));
      end
      return {IW'(p), d[3], d[2], d[1], d[0]};
   endfunction

   task automatic set_din(input int base, input int p, input bit special);
      logic [3:0][DW-1:0] sp;
      sp = {18'h1FFFF, 18'h20000, 18'h00000, 18'h3FFFF};
      bus.din_0 = special ? sp : win(0, base + p);
      bus.din_1 = special ? sp : win(1, base + p);
      bus.din_2 = special ? sp : win(2, base + p);
      bus.din_3 = special ? sp : win(3, base + p);
   endtask

   task automatic clear_din();
      bus.din_0 = '0;
      bus.din_1 = '0;
      bus.din_2 = '0;
      bus.din_3 = '0;
   endtask

   // One rd per cycle for NWIN windows (optionally a 26th), checking full timing.
   task automatic send_frame(input int base, input bit special0, input bit extra26);
      for (int p = 0; p < NWIN; p++) exp_q.push_back(exp_entry(p, base, special0 && p == 0));
      for (int i = 0; i <= NWIN + 2; i++) begin
         @(posedge clk); #1;
         bus.rd = (i < NWIN) || (extra26 && i == NWIN);
         if (i >= 1 && i <= NWIN) set_din(base, i - 1, special0 && i == 1);
         else if (extra26 && i == NWIN + 1) begin
            bus.din_0 = {4{18'h30000}};
            bus.din_1 = {4{18'h30000}};
            bus.din_2 = {4{18'h30000}};
            bus.din_3 = {4{18'h30000}};
         end else clear_din();
         if (i == NWIN)     check("full_early", bus.full, 1'b0);
         if (i == NWIN + 1) check("full_set", bus.full, 1'b1);
      end
      bus.rd = 1'b0;
      clear_din();
   endtask

   task automatic drain(input bit toggle);
      int start_done;
      bit ok;
      start_done = done_cnt;
      ok = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         bus.out_rdy = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         if (done_cnt != start_done) begin
            ok = 1'b1;
            break;
         end
      end
      bus.out_rdy = 1'b0;
      check("drain_done_seen", ok, 1'b1);
      check("xfer_count", xfer_cnt, NWIN);
      check("queue_empty", exp_q.size(), 0);
      xfer_cnt = 0;
   endtask

   // Output monitor: pops one expected entry per accepted position.
   always @(negedge clk) begin
      logic [EW-1:0] cur;
      logic [EW-1:0] exp;
      if (rst_n) begin
         cur = {bus.out_idx, bus.dout_3, bus.dout_2, bus.dout_1, bus.dout_0};
         if (exp_done || bus.done) check("done_pulse", bus.done, exp_done);
         if (bus.done) done_cnt++;
         exp_done = 1'b0;
         if (hold_vld) begin
            check("stall_vld", bus.out_vld, 1'b1);
            check("stall_data", cur, hold_val);
         end
         hold_vld = 1'b0;
         if (bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) check("unexpected_xfer", cur, '0);
            else begin
               exp = exp_q.pop_front();
               check("xfer_data", cur, exp);
               if (exp[EW-1 -: IW] == IW'(NWIN - 1)) exp_done = 1'b1;
            end
            xfer_cnt++;
         end else if (bus.out_vld) begin
            hold_vld = 1'b1;
            hold_val = cur;
         end
      end
   end

   initial begin
      bit hit;
      bus.rd = 1'b0;
      bus.out_rdy = 1'b0;
      clear_din();
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_full", bus.full, 1'b0);
      check("rst_vld", bus.out_vld, 1'b0);
      check("rst_idx", bus.out_idx, '0);
      check("rst_done", bus.done, 1'b0);
      check("rst_dout", {bus.dout_3, bus.dout_2, bus.dout_1, bus.dout_0}, '0);

      // Basic frame, continuous drain.
      send_frame(1, 1'b0, 1'b0);
      drain(1'b0);
      // Same frame, stalled drain.
      send_frame(1, 1'b0, 1'b0);
      drain(1'b1);
      // Full-width unsigned maximum in window 0.
      send_frame(30, 1'b1, 1'b0);
      drain(1'b0);
      // A 26th read straight after the 25th is dropped.
      send_frame(40, 1'b0, 1'b1);
      drain(1'b0);

      // Abort after 10 captured windows, then a fresh frame.
      for (int i = 0; i <= 10; i++) begin
         @(posedge clk); #1;
         bus.rd = (i < 10);
         if (i >= 1) set_din(100, i - 1, 1'b0);
      end
      @(posedge clk); #1;
      bus.rd = 1'b0;
      clear_din();
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
      check("abort_full", bus.full, 1'b0);
      send_frame(60, 1'b0, 1'b0);
      drain(1'b0);

      // Asynchronous reset in the middle of a drain.
      send_frame(70, 1'b0, 1'b0);
      bus.out_rdy = 1'b1;
      hit = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk); #1;
         if (xfer_cnt >= 5) begin
            hit = 1'b1;
            break;
         end
      end
      check("mid_drain_reached", hit, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_vld", bus.out_vld, 1'b0);
      check("arst_full", bus.full, 1'b0);
      check("arst_done", bus.done, 1'b0);
      bus.out_rdy = 1'b0;
      exp_q.delete();
      hold_vld = 1'b0;
      exp_done = 1'b0;
      xfer_cnt = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      send_frame(80, 1'b0, 1'b0);
      drain(1'b0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/l2_pool.md
Name: l2_pool

Overview:
- 2x2 max-pool stage directly downstream of layer 2.
- Snoops layer 2's output-RAM read strobe and captures each returned 2x2 window on all 4 channels. Reduces each window to its maximum and stores the 25 pooled results per channel.
- Once all 25 positions are stored, streams them (4 channels in parallel) to the next layer over a valid/ready handshake.

Parameters:
- DW, 18, data width of every activation word.
- NWIN, 25, pooled positions per frame (5x5 grid of 2x2 windows).
- IW, 5, index width; must satisfy 2^IW >= NWIN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rd  input  1  layer 2 RAM read strobe; window data arrives the following cycle.
- din_0  input  DW x4  channel 0 window words [3:0] from layer 2 RAM.
- din_1  input  DW x4  channel 1 window.
- din_2  input  DW x4  channel 2 window.
- din_3  input  DW x4  channel 3 window.
- tx_done  input  1  frame-abort/restart pulse, shared with layer 2.
- full  output  1  all NWIN positions captured; the block is draining.
- out_vld  output  1  dout_* and out_idx hold a valid pooled position.
- out_rdy  input  1  downstream accepts the current position.
- out_idx  output  IW  position index 0..NWIN-1 of the current output.
- dout_0..dout_3  output  DW each  pooled value of channel 0..3 at out_idx.
- done  output  1  one-cycle pulse after the last position is accepted.

Behaviour:
- Interface: clk, with rst_n asynchronous active-low. All other state is synchronous to clk.
- Reset values: full=0, out_vld=0, out_idx=0, dout_*=0, done=0. wr_ptr=0, rd_ptr=0, rd_d=0, state=FILL.
- tx_done: synchronous clear to the reset values. It has priority over every other event in the same cycle.
- States: FILL and DRAIN.
- FILL, capture:
  - rd_d <= rd.
  - When rd_d=1, each channel computes max(din_c[0..3]) as an unsigned compare; inputs are post-ReLU and non-negative.
  - The result is written to buf_c[wr_ptr], then wr_ptr increments.
  - Latency from rd to buffer write: 2 edges (capture edge at t+1, write edge at t+2).
- FILL to DRAIN: on the edge that writes wr_ptr=NWIN-1. full=1 from the next cycle.
- rd while in DRAIN: ignored. No write occurs and the buffer contents are unchanged. A window whose rd_d falls on the transition edge is the NWIN+1th and is dropped.
- DRAIN, output:
  - Outputs are registered from buf_c[rd_ptr].
  - out_vld rises 1 cycle after entering DRAIN, with out_idx=0.
  - Transfer occurs on any edge where out_vld and out_rdy are both 1. On transfer, rd_ptr increments and the next position is presented on the following cycle. Back-to-back transfers at 1 per cycle are allowed.
  - While out_vld=1 and out_rdy=0, dout_*, out_idx and out_vld hold stable.
- Last transfer (out_idx=NWIN-1):
  - out_vld=0, full=0 and done=1 for exactly one cycle.
  - wr_ptr and rd_ptr clear to 0 and the state returns to FILL.
  - Buffer contents are not cleared; they are overwritten by the next frame.
- Widths: max is computed at DW bits with no truncation. out_idx equals rd_ptr.
- Equal values: when inputs tie, the result is that common value. Ordering among equal inputs is irrelevant.

Test Plan:
- Reset, then 25 rd pulses one per cycle. Each window is {k, 3k, 2k, k+1} on ch0 and the reverse order on ch1-3. Expect full=1 two cycles after the last rd. Drain with out_rdy=1 -> out_idx 0..24 on consecutive cycles, dout_c=3k, done pulse one cycle after idx 24.
- Same frame with out_rdy toggling 1,0,0,1 -> each position holds stable while stalled. No position is skipped or duplicated; the transfer count is exactly 25.
- Window values {0x3FFFF, 0, 0x20000, 0x1FFFF} -> dout=0x3FFFF (full-width unsigned max, no sign interpretation).
- 26th rd issued one cycle after the 25th -> ignored. Buffer index 0 still holds frame value and the drain output is unchanged.
- tx_done asserted mid-FILL (after 10 writes), then a full 25-window frame -> out_idx starts at 0 with new-frame data and full asserts only after 25 new writes.
- rst_n dropped mid-DRAIN asynchronously -> out_vld, full, done are 0 immediately. The next frame completes normally.
